// File: rtl/pe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pe_ctrl_pkg
// Shared definitions for the PE tile controller:
//   - state_e  : controller FSM state encoding (3 bits)
//   - calc_kw  : counter width needed to hold values 0..max_val
// -----------------------------------------------------------------------------
package pe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_OUTPUT = 3'd4
  } state_e;

  // Bits needed to represent 0..max_val; never less than 1.
  function automatic int calc_kw(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pe_ctrl_beat_cnt.sv
// -----------------------------------------------------------------------------
// pe_ctrl_beat_cnt
// Loadable down-counter with zero / one flags. Load has priority over
// decrement; decrement stops at zero.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   i_load       load i_load_val
//   i_load_val   [W-1:0] value to load
//   i_dec        decrement by one (ignored while zero)
//   o_zero       count == 0
//   o_one        count == 1
// -----------------------------------------------------------------------------
module pe_ctrl_beat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero,
  output logic         o_one
);

  logic [W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs regardless of process order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);
  assign o_one  = (r_count == W'(1));

endmodule

// File: rtl/pe_tile_controller.sv
// -----------------------------------------------------------------------------
// pe_tile_controller
// Sequences one reduction tile of length K over a NUM_MACS-lane PE:
// clear accumulators, stream K operand beats, drain the MAC pipeline,
// capture the accumulators and hand them downstream.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   start, cfg_k_len              tile request and length (clamped to K_MAX)
//   busy, done                    not-IDLE flag, result-handshake pulse
//   in_valid/in_ready             operand beat handshake
//   in_a_flat, in_b_flat          signed operand lanes
//   pe_rst_acc                    PE accumulator clear
//   pe_a_flat, pe_b_flat          registered operands to the PE
//   pe_results_flat               PE accumulators
//   res_valid/res_ready, res_flat result handshake and captured results
//   stall_cnt                     only with PE_CTRL_STALL_CNT_EN defined
//
// Optional feature macro: PE_CTRL_STALL_CNT_EN (adds stall_cnt output).
// -----------------------------------------------------------------------------
module pe_tile_controller
  import pe_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_MACS    = 4,
  parameter int K_MAX       = 1024,
  parameter int MAC_LATENCY = 1,
  localparam int KW         = calc_kw(K_MAX)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [KW-1:0]                  cfg_k_len,
  output logic                           busy,
  output logic                           done,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_MACS*DATA_WIDTH-1:0] in_a_flat,
  input  logic [NUM_MACS*DATA_WIDTH-1:0] in_b_flat,
  output logic                           pe_rst_acc,
  output logic [NUM_MACS*DATA_WIDTH-1:0] pe_a_flat,
  output logic [NUM_MACS*DATA_WIDTH-1:0] pe_b_flat,
  input  logic [NUM_MACS*2*DATA_WIDTH-1:0] pe_results_flat,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [NUM_MACS*2*DATA_WIDTH-1:0] res_flat
`ifdef PE_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]                    stall_cnt
`endif
);

  localparam int DCW = calc_kw(MAC_LATENCY);
  localparam int OW  = NUM_MACS * DATA_WIDTH;
  localparam int RW  = NUM_MACS * 2 * DATA_WIDTH;

  state_e          r_state;
  state_e          w_next_state;
  logic [OW-1:0]   r_pe_a;
  logic [OW-1:0]   r_pe_b;
  logic [RW-1:0]   r_res;

  logic            w_accept_start;
  logic            w_beat;
  logic [KW-1:0]   w_k_clamped;
  logic            w_beat_zero;
  logic            w_beat_one;
  logic            w_drain_load;
  logic            w_drain_zero;
  logic            w_unused_drain_one;

  assign w_accept_start = (r_state == ST_IDLE) && start;
  assign w_beat         = (r_state == ST_STREAM) && in_valid;
  assign w_k_clamped    = (cfg_k_len > KW'(K_MAX)) ? KW'(K_MAX) : cfg_k_len;
  // Load the drain counter on the single transition into DRAIN.
  assign w_drain_load   = (w_next_state == ST_DRAIN) && (r_state != ST_DRAIN);

  // Beat counter doubles as the latched tile length: loaded on start, it is
  // the only copy of k_len, so later cfg_k_len changes cannot reach the tile.
  pe_ctrl_beat_cnt #(.W(KW)) u_beat_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept_start),
    .i_load_val (w_k_clamped),
    .i_dec      (w_beat),
    .o_zero     (w_beat_zero),
    .o_one      (w_beat_one)
  );

  // Loaded with MAC_LATENCY; DRAIN ends when it reaches zero, giving
  // MAC_LATENCY+1 drain cycles. Only the zero flag is needed here.
  pe_ctrl_beat_cnt #(.W(DCW)) u_drain_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_drain_load),
    .i_load_val (DCW'(MAC_LATENCY)),
    .i_dec      (r_state == ST_DRAIN),
    .o_zero     (w_drain_zero),
    .o_one      (w_unused_drain_one)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b1;
    in_ready     = 1'b0;
    pe_rst_acc   = 1'b0;
    res_valid    = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_next_state = ST_CLEAR;
      end
      ST_CLEAR: begin
        pe_rst_acc   = 1'b1;
        w_next_state = w_beat_zero ? ST_DRAIN : ST_STREAM;
      end
      ST_STREAM: begin
        in_ready = 1'b1;
        if (in_valid && w_beat_one) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_drain_zero) w_next_state = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          done         = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Zero operands on every non-beat cycle keep the free-running MACs idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pe_a <= '0;
      r_pe_b <= '0;
    end else begin
      r_pe_a <= w_beat ? in_a_flat : '0;
      r_pe_b <= w_beat ? in_b_flat : '0;
    end
  end

  // Capture on the last drain cycle, when the final beat has landed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_res <= '0;
    end else if ((r_state == ST_DRAIN) && w_drain_zero) begin
      r_res <= pe_results_flat;
    end
  end

  assign pe_a_flat = r_pe_a;
  assign pe_b_flat = r_pe_b;
  assign res_flat  = r_res;

`ifdef PE_CTRL_STALL_CNT_EN
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = ((r_state == ST_STREAM) && !in_valid) ||
                   ((r_state == ST_OUTPUT) && !res_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_accept_start) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pe_tile_controller.sv
// -----------------------------------------------------------------------------
// tb_pe_tile_controller
// Directed bench for pe_tile_controller with a behavioural MAC_LATENCY=1 PE
// (free-running accumulators cleared by pe_rst_acc).
// -----------------------------------------------------------------------------
module tb_pe_tile_controller;

  localparam int DW   = 16;
  localparam int NM   = 4;
  localparam int KMAX = 1024;
  localparam int ML   = 1;
  localparam int KW   = 11;
  localparam int OW   = NM * DW;
  localparam int RW   = NM * 2 * DW;

  logic          clk;
  logic          rst;
  logic          start;
  logic [KW-1:0] cfg_k_len;
  logic          busy;
  logic          done;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] in_a_flat;
  logic [OW-1:0] in_b_flat;
  logic          pe_rst_acc;
  logic [OW-1:0] pe_a_flat;
  logic [OW-1:0] pe_b_flat;
  logic [RW-1:0] pe_results_flat = '0;
  logic          res_valid;
  logic          res_ready;
  logic [RW-1:0] res_flat;
`ifdef PE_CTRL_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  pe_tile_controller #(
    .DATA_WIDTH  (DW),
    .NUM_MACS    (NM),
    .K_MAX       (KMAX),
    .MAC_LATENCY (ML)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .cfg_k_len       (cfg_k_len),
    .busy            (busy),
    .done            (done),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_a_flat       (in_a_flat),
    .in_b_flat       (in_b_flat),
    .pe_rst_acc      (pe_rst_acc),
    .pe_a_flat       (pe_a_flat),
    .pe_b_flat       (pe_b_flat),
    .pe_results_flat (pe_results_flat),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_flat        (res_flat)
`ifdef PE_CTRL_STALL_CNT_EN
    ,
    .stall_cnt       (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural PE: product of lane i lands in the accumulator one cycle later.
  function automatic logic [31:0] lane_prod(input logic [OW-1:0] a,
                                            input logic [OW-1:0] b,
                                            input int i);
    logic signed [31:0] pa;
    logic signed [31:0] pb;
    pa = $signed(a[i*DW +: DW]);
    pb = $signed(b[i*DW +: DW]);
    return pa * pb;
  endfunction

  always @(posedge clk) begin
    if (pe_rst_acc) begin
      pe_results_flat <= '0;
    end else begin
      for (int i = 0; i < NM; i++)
        pe_results_flat[i*2*DW +: 2*DW] <= pe_results_flat[i*2*DW +: 2*DW] +
                                           lane_prod(pe_a_flat, pe_b_flat, i);
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [OW-1:0] ba [8];
  logic [OW-1:0] bb [8];

  // Results of the most recent run_tile call.
  int            rv_rel;
  int            done_rel;
  int            done_cnt;
  int            ir_seen;
  int            clr_rel;
  int            clr_cnt;
  bit            stable_ok;
  bit            finished;
  logic [RW-1:0] res_got;

  // Runs one tile. Relative cycle 0 is the cycle start is driven high.
  // bub0/bub1: relative cycles with in_valid low; hold: cycles res_ready is
  // held low after res_valid rises; mid_rel >= 0 pulses start at mid_rel and
  // mid_rel+1 and changes cfg_k_len from mid_rel onwards.
  task automatic run_tile(input int k, input int bub0, input int bub1,
                          input int hold, input int mid_rel);
    int s;
    int rel;
    int idx;
    int rvn;
    int post;
    logic [RW-1:0] res_first;
    rv_rel = -1; done_rel = -1; done_cnt = 0; ir_seen = 0;
    clr_rel = -1; clr_cnt = 0; stable_ok = 1'b1; finished = 1'b0;
    idx = 0; rvn = 0; post = 0; res_first = '0; res_got = '0;
    @(posedge clk); #1;
    s = cyc;
    start = 1'b1;
    cfg_k_len = KW'(k);
    for (int n = 0; n < 1200; n++) begin
      rel = cyc - s;
      if (rel > 0) start = (mid_rel >= 0) && (rel == mid_rel || rel == mid_rel + 1);
      if (mid_rel >= 0 && rel >= mid_rel) cfg_k_len = KW'(1);
      in_valid  = (idx < k) && (rel != bub0) && (rel != bub1);
      in_a_flat = ba[idx % 8];
      in_b_flat = bb[idx % 8];
      res_ready = (rvn >= hold);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (in_ready) ir_seen++;
      if (pe_rst_acc) begin clr_cnt++; clr_rel = rel; end
      if (res_valid) begin
        if (rv_rel < 0) begin
          rv_rel    = rel;
          res_first = res_flat;
        end else if (res_flat !== res_first) begin
          stable_ok = 1'b0;
        end
        rvn++;
      end
      if (done) begin
        done_cnt++;
        if (done_rel < 0) done_rel = rel;
        res_got  = res_flat;
        finished = 1'b1;
      end
      @(posedge clk); #1;
      if (finished) post++;
      if (post >= 3) break;
    end
    check("tile_finished", finished, 1'b1);
    start = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
  endtask

  task automatic load_t1_data();
    for (int i = 0; i < 8; i++) begin
      ba[i] = '0;
      bb[i] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      ba[i] = OW'(i + 1);
      bb[i] = OW'(i + 5);
    end
  endtask

  initial begin
    int beats;
    rst = 1'b0; start = 1'b0; cfg_k_len = '0; in_valid = 1'b0;
    in_a_flat = '0; in_b_flat = '0; res_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin ba[i] = '0; bb[i] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",      busy,       1'b0);
    check("rst_done",      done,       1'b0);
    check("rst_in_ready",  in_ready,   1'b0);
    check("rst_res_valid", res_valid,  1'b0);
    check("rst_pe_rst",    pe_rst_acc, 1'b0);
    check("rst_pe_a",      pe_a_flat,  '0);
    check("rst_res",       res_flat,   '0);
    rst = 1'b1;

    // Basic tile: lane0 sum 1*5+2*6+3*7+4*8 = 70, res_valid at cycle 8.
    load_t1_data();
    run_tile(4, -1, -1, 0, -1);
    check("t1_res",      res_got,  128'd70);
    check("t1_rv_cycle", rv_rel,   8);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_clr_rel",  clr_rel,  1);
    check("t1_clr_cnt",  clr_cnt,  1);
    check("t1_ir_beats", ir_seen,  4);

    // Bubbles on cycles 3 and 5 add two cycles.
    run_tile(4, 3, 5, 0, -1);
    check("t2_res",      res_got,  128'd70);
    check("t2_rv_cycle", rv_rel,   10);
    check("t2_done_cnt", done_cnt, 1);
`ifdef PE_CTRL_STALL_CNT_EN
    check("t2_stall",    stall_cnt, 32'd2);
`endif

    // K = 0: CLEAR straight to DRAIN, zero results.
    run_tile(0, -1, -1, 0, -1);
    check("t3_res",      res_got,  '0);
    check("t3_rv_cycle", rv_rel,   4);
    check("t3_done_cnt", done_cnt, 1);
    check("t3_in_ready", ir_seen,  0);

    // Signed extremes in all lanes, downstream stalled for 5 cycles.
    for (int i = 0; i < 2; i++) begin
      ba[i] = {NM{16'h8000}};
      bb[i] = {NM{16'h8000}};
    end
    run_tile(2, -1, -1, 5, -1);
    check("t4_res",       res_got,   {NM{32'h8000_0000}});
    check("t4_rv_cycle",  rv_rel,    6);
    check("t4_done_rel",  done_rel,  11);
    check("t4_stable",    stable_ok, 1'b1);
    check("t4_done_cnt",  done_cnt,  1);
`ifdef PE_CTRL_STALL_CNT_EN
    check("t4_stall",     stall_cnt, 32'd5);
`endif

    // Reset mid-stream after 2 of 4 beats.
    load_t1_data();
    @(posedge clk); #1;
    start = 1'b1; cfg_k_len = KW'(4);
    beats = 0;
    for (int n = 0; n < 20 && beats < 2; n++) begin
      @(posedge clk); #1;
      start     = 1'b0;
      in_valid  = 1'b1;
      in_a_flat = ba[beats];
      in_b_flat = bb[beats];
      @(negedge clk);
      if (in_valid && in_ready) beats++;
    end
    check("t5_two_beats", beats, 2);
    #2 rst = 1'b0;
    #1;
    check("t5_busy",      busy,       1'b0);
    check("t5_in_ready",  in_ready,   1'b0);
    check("t5_res_valid", res_valid,  1'b0);
    check("t5_done",      done,       1'b0);
    check("t5_pe_rst",    pe_rst_acc, 1'b0);
    check("t5_pe_a",      pe_a_flat,  '0);
    check("t5_pe_b",      pe_b_flat,  '0);
    check("t5_res",       res_flat,   '0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin ba[i] = '0; bb[i] = '0; end
    ba[0] = OW'(3);
    bb[0] = OW'(4);
    run_tile(1, -1, -1, 0, -1);
    check("t5_new_res",   res_got,  128'd12);
    check("t5_new_rv",    rv_rel,   5);
    check("t5_new_done",  done_cnt, 1);

    // start while busy and cfg_k_len changed mid-tile are ignored.
    load_t1_data();
    run_tile(4, -1, -1, 0, 3);
    check("t6_res",       res_got,  128'd70);
    check("t6_rv_cycle",  rv_rel,   8);
    check("t6_done_cnt",  done_cnt, 1);
    check("t6_idle",      busy,     1'b0);

    // Length above K_MAX clamps to 1024 beats of 1*1 on lane0.
    for (int i = 0; i < 8; i++) begin ba[i] = OW'(1); bb[i] = OW'(1); end
    run_tile(2047, -1, -1, 0, -1);
    check("t7_res",       res_got,  128'd1024);
    check("t7_rv_cycle",  rv_rel,   1028);
    check("t7_done_cnt",  done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
